// File: rtl/riscv_definitions.sv
// Shared RV32I decode types: opcodes, ALU operations, operand selects,
// immediate formats and the registered decode bundle.
package riscv_definitions;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR   = 5;

    typedef enum logic [6:0] {
        ALU_S   = 7'b0110011,
        ALUI_S  = 7'b0010011,
        LOAD_S  = 7'b0000011,
        STORE_S = 7'b0100011,
        BRCH_S  = 7'b1100011,
        JAL     = 7'b1101111,
        JALR    = 7'b1100111,
        LUI     = 7'b0110111,
        AUIPC   = 7'b0010111
    } opcode_t;

    // SLT/SLTU share the signed/unsigned less-than comparators used by branches.
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_SLL    = 4'd2,
        ALU_LT     = 4'd3,
        ALU_LTU    = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_SRL    = 4'd6,
        ALU_SRA    = 4'd7,
        ALU_OR     = 4'd8,
        ALU_AND    = 4'd9,
        ALU_EQUAL  = 4'd10,
        ALU_NEQUAL = 4'd11,
        ALU_GT     = 4'd12,
        ALU_GTU    = 4'd13,
        ALU_BPS2   = 4'd14
    } alu_op_t;

    typedef enum logic {SRC1_RS1 = 1'b0, SRC1_PC  = 1'b1} alu_src1_e;
    typedef enum logic {SRC2_RS2 = 1'b0, SRC2_IMM = 1'b1} alu_src2_e;

    typedef enum logic [2:0] {IMM_I, IMM_IS, IMM_S, IMM_B, IMM_U, IMM_J} imm_src_t;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [REG_ADDR-1:0]   rd;
        logic [REG_ADDR-1:0]   rs1;
        logic [REG_ADDR-1:0]   rs2;
        logic [2:0]            funct3;
        logic [DATA_WIDTH-1:0] imm;
        alu_op_t               alu_op;
        alu_src1_e             alu_src1;
        alu_src2_e             alu_src2;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  branch;
        logic                  jump;
        logic                  illegal;
    } decode_bundle_t;

    localparam decode_bundle_t BUNDLE_RESET = '{
        pc: '0, rd: '0, rs1: '0, rs2: '0, funct3: '0, imm: '0,
        alu_op: ALU_ADD, alu_src1: SRC1_RS1, alu_src2: SRC2_RS2,
        reg_write: 1'b0, mem_read: 1'b0, mem_write: 1'b0,
        branch: 1'b0, jump: 1'b0, illegal: 1'b0
    };

    function automatic alu_op_t alu_op_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_LT;
            F3_SLTU: return ALU_LTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return alt ? ALU_SRA : ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/riscv_imm_gen.sv
// Combinational RV32I immediate generator; the opcode bits [6:0] never
// contribute to an immediate, so only instr[31:7] is taken.
module riscv_imm_gen
    import riscv_definitions::*;
(
    input  logic [DATA_WIDTH-1:7] instr,
    input  imm_src_t              imm_src,
    output logic [DATA_WIDTH-1:0] imm
);

    always_comb begin
        imm = '0;
        case (imm_src)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_IS:  imm = {27'b0, instr[24:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/riscv_decode_stage.sv
// Registered RV32I decode stage with a one-entry skid buffer holding an
// already-decoded bundle, so in_ready depends only on local state.
module riscv_decode_stage
    import riscv_definitions::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_instr,
    input  logic [DATA_WIDTH-1:0] in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pc,
    output logic [REG_ADDR-1:0]   out_rd,
    output logic [REG_ADDR-1:0]   out_rs1,
    output logic [REG_ADDR-1:0]   out_rs2,
    output logic [2:0]            out_funct3,
    output logic [DATA_WIDTH-1:0] out_imm,
    output alu_op_t               out_alu_op,
    output alu_src1_e             out_alu_src1,
    output alu_src2_e             out_alu_src2,
    output logic                  out_reg_write,
    output logic                  out_mem_read,
    output logic                  out_mem_write,
    output logic                  out_branch,
    output logic                  out_jump,
    output logic                  out_illegal
);

    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    imm_src_t              imm_src;
    logic [DATA_WIDTH-1:0] imm;
    logic                  illegal;
    decode_bundle_t        ctrl;
    decode_bundle_t        decoded;
    decode_bundle_t        out_bundle;
    decode_bundle_t        skid_bundle;
    logic                  skid_valid;
    logic                  accept;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    riscv_imm_gen u_imm_gen (
        .instr   (in_instr[DATA_WIDTH-1:7]),
        .imm_src (imm_src),
        .imm     (imm)
    );

    always_comb begin
        ctrl          = BUNDLE_RESET;
        ctrl.pc       = in_pc;
        ctrl.rd       = in_instr[11:7];
        ctrl.rs1      = in_instr[19:15];
        ctrl.rs2      = in_instr[24:20];
        ctrl.funct3   = funct3;
        imm_src       = IMM_I;
        illegal       = 1'b0;
        case (opcode)
            ALU_S: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = alu_op_from_funct3(funct3, funct7[5]);
                if ((funct7 != 7'b0 && funct7 != FUNCT7_ALT) ||
                    (funct7 == FUNCT7_ALT && funct3 != F3_ADD && funct3 != F3_SR))
                    illegal = 1'b1;
            end
            ALUI_S: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src2  = SRC2_IMM;
                // Only the right-shift form honours funct7[5]; ADDI must never become SUB.
                ctrl.alu_op    = alu_op_from_funct3(funct3, (funct3 == F3_SR) && funct7[5]);
                if (funct3 == F3_SLL) begin
                    imm_src = IMM_IS;
                    if (funct7 != 7'b0) illegal = 1'b1;
                end else if (funct3 == F3_SR) begin
                    imm_src = IMM_IS;
                    if (funct7 != 7'b0 && funct7 != FUNCT7_ALT) illegal = 1'b1;
                end
            end
            LOAD_S: begin
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                if (funct3 == 3'b011 || funct3[2:1] == 2'b11) illegal = 1'b1;
            end
            STORE_S: begin
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.mem_write = 1'b1;
                imm_src        = IMM_S;
                if (funct3 >= 3'b011) illegal = 1'b1;
            end
            BRCH_S: begin
                ctrl.branch = 1'b1;
                imm_src     = IMM_B;
                case (funct3)
                    F3_BEQ:  ctrl.alu_op = ALU_EQUAL;
                    F3_BNE:  ctrl.alu_op = ALU_NEQUAL;
                    F3_BLT:  ctrl.alu_op = ALU_LT;
                    F3_BGE:  ctrl.alu_op = ALU_GT;
                    F3_BLTU: ctrl.alu_op = ALU_LTU;
                    F3_BGEU: ctrl.alu_op = ALU_GTU;
                    default: illegal     = 1'b1;
                endcase
            end
            JAL: begin
                ctrl.alu_src1  = SRC1_PC;
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                imm_src        = IMM_J;
            end
            JALR: begin
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.jump      = 1'b1;
                ctrl.reg_write = 1'b1;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            LUI: begin
                ctrl.alu_op    = ALU_BPS2;
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.reg_write = 1'b1;
                imm_src        = IMM_U;
            end
            AUIPC: begin
                ctrl.alu_src1  = SRC1_PC;
                ctrl.alu_src2  = SRC2_IMM;
                ctrl.reg_write = 1'b1;
                imm_src        = IMM_U;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal instructions still flow downstream but must cause no side effects.
        if (illegal) begin
            ctrl.reg_write = 1'b0;
            ctrl.mem_read  = 1'b0;
            ctrl.mem_write = 1'b0;
            ctrl.branch    = 1'b0;
            ctrl.jump      = 1'b0;
        end
        ctrl.illegal = illegal;
    end

    always_comb begin
        decoded     = ctrl;
        decoded.imm = imm;
    end

    assign in_ready = !skid_valid;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            skid_valid  <= 1'b0;
            out_bundle  <= BUNDLE_RESET;
            skid_bundle <= BUNDLE_RESET;
        end else if (flush) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!out_valid || out_ready) begin
            // The skid entry is older than anything upstream, so it drains first.
            if (skid_valid) begin
                out_bundle <= skid_bundle;
                out_valid  <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                out_bundle <= decoded;
                out_valid  <= 1'b1;
            end else begin
                out_valid  <= 1'b0;
            end
        end else if (accept) begin
            skid_bundle <= decoded;
            skid_valid  <= 1'b1;
        end
    end

    assign out_pc        = out_bundle.pc;
    assign out_rd        = out_bundle.rd;
    assign out_rs1       = out_bundle.rs1;
    assign out_rs2       = out_bundle.rs2;
    assign out_funct3    = out_bundle.funct3;
    assign out_imm       = out_bundle.imm;
    assign out_alu_op    = out_bundle.alu_op;
    assign out_alu_src1  = out_bundle.alu_src1;
    assign out_alu_src2  = out_bundle.alu_src2;
    assign out_reg_write = out_bundle.reg_write;
    assign out_mem_read  = out_bundle.mem_read;
    assign out_mem_write = out_bundle.mem_write;
    assign out_branch    = out_bundle.branch;
    assign out_jump      = out_bundle.jump;
    assign out_illegal   = out_bundle.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Table-driven scoreboard bench for riscv_decode_stage plus hand-written
// backpressure, flush and reset sequences.
module tb_riscv_decode_stage;
    import riscv_definitions::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [2:0]  out_funct3;
    logic [31:0] out_imm;
    alu_op_t     out_alu_op;
    alu_src1_e   out_alu_src1;
    alu_src2_e   out_alu_src2;
    logic        out_reg_write;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_branch;
    logic        out_jump;
    logic        out_illegal;

    riscv_decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_rd        (out_rd),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_funct3    (out_funct3),
        .out_imm       (out_imm),
        .out_alu_op    (out_alu_op),
        .out_alu_src1  (out_alu_src1),
        .out_alu_src2  (out_alu_src2),
        .out_reg_write (out_reg_write),
        .out_mem_read  (out_mem_read),
        .out_mem_write (out_mem_write),
        .out_branch    (out_branch),
        .out_jump      (out_jump),
        .out_illegal   (out_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]    instr;
        decode_bundle_t exp;
    } vec_t;

    localparam int NUM_VECS = 20;
    vec_t           vecs [NUM_VECS];
    decode_bundle_t exp_q [$];
    decode_bundle_t cur_exp;
    int             n_checks = 0;
    int             n_fail   = 0;

    function automatic decode_bundle_t mk(
        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
        input logic [2:0] f3, input logic [31:0] imm, input alu_op_t op,
        input alu_src1_e s1, input alu_src2_e s2, input logic rw, input logic mr,
        input logic mw, input logic br, input logic jp, input logic ill);
        decode_bundle_t b;
        b.pc = '0; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.funct3 = f3; b.imm = imm;
        b.alu_op = op; b.alu_src1 = s1; b.alu_src2 = s2; b.reg_write = rw;
        b.mem_read = mr; b.mem_write = mw; b.branch = br; b.jump = jp; b.illegal = ill;
        return b;
    endfunction

    function automatic decode_bundle_t sampleOutput();
        decode_bundle_t b;
        b.pc = out_pc; b.rd = out_rd; b.rs1 = out_rs1; b.rs2 = out_rs2;
        b.funct3 = out_funct3; b.imm = out_imm; b.alu_op = out_alu_op;
        b.alu_src1 = out_alu_src1; b.alu_src2 = out_alu_src2;
        b.reg_write = out_reg_write; b.mem_read = out_mem_read;
        b.mem_write = out_mem_write; b.branch = out_branch; b.jump = out_jump;
        b.illegal = out_illegal;
        return b;
    endfunction

    task automatic checkSignal(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Compares the bundle leaving the stage against the oldest scoreboard entry.
    task automatic checkOutput();
        decode_bundle_t act;
        decode_bundle_t exp;
        act = sampleOutput();
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL unexpected_output: got bundle 0x%h, expected no output", act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                n_fail++;
                $display("[TB] FAIL bundle pc=0x%08h: got 0x%h, expected 0x%h", exp.pc, act, exp);
            end
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input decode_bundle_t e, input logic ordy, input logic fl);
        in_valid   = v;
        in_instr   = instr;
        in_pc      = pc;
        out_ready  = ordy;
        flush      = fl;
        cur_exp    = e;
        cur_exp.pc = pc;
    endtask

    // Called just after a falling edge: evaluates the handshakes of the coming edge.
    task automatic stepCycle();
        #1;
        if (flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) checkOutput();
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 32'h0, 32'h0, BUNDLE_RESET, ordy, 1'b0);
    endtask

    task automatic drain(input string name);
        idle(1'b1);
        for (int k = 0; k < 20 && (exp_q.size() != 0 || out_valid); k++) stepCycle();
        checkSignal({name, "_queue_empty"}, exp_q.size(), 32'd0);
        checkSignal({name, "_valid_low"}, {31'b0, out_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h002081B3, mk(3, 1, 2, 3'd0, 32'h2,        ALU_ADD,   SRC1_RS1, SRC2_RS2, 1, 0, 0, 0, 0, 0)};
        vecs[1]  = '{32'h402081B3, mk(3, 1, 2, 3'd0, 32'h402,      ALU_SUB,   SRC1_RS1, SRC2_RS2, 1, 0, 0, 0, 0, 0)};
        vecs[2]  = '{32'h40335293, mk(5, 6, 3, 3'd5, 32'h3,        ALU_SRA,   SRC1_RS1, SRC2_IMM, 1, 0, 0, 0, 0, 0)};
        vecs[3]  = '{32'hFE208EE3, mk(29, 1, 2, 3'd0, 32'hFFFFFFFC, ALU_EQUAL, SRC1_RS1, SRC2_RS2, 0, 0, 0, 1, 0, 0)};
        vecs[4]  = '{32'h123450B7, mk(1, 8, 3, 3'd5, 32'h12345000, ALU_BPS2,  SRC1_RS1, SRC2_IMM, 1, 0, 0, 0, 0, 0)};
        vecs[5]  = '{32'h00508113, mk(2, 1, 5, 3'd0, 32'h5,        ALU_ADD,   SRC1_RS1, SRC2_IMM, 1, 0, 0, 0, 0, 0)};
        vecs[6]  = '{32'hFFFFFFFF, mk(31, 31, 31, 3'd7, 32'hFFFFFFFF, ALU_ADD, SRC1_RS1, SRC2_RS2, 0, 0, 0, 0, 0, 1)};
        vecs[7]  = '{32'h0000707F, mk(0, 0, 0, 3'd7, 32'h0,        ALU_ADD,   SRC1_RS1, SRC2_RS2, 0, 0, 0, 0, 0, 1)};
        vecs[8]  = '{32'h00007003, mk(0, 0, 0, 3'd7, 32'h0,        ALU_ADD,   SRC1_RS1, SRC2_IMM, 0, 0, 0, 0, 0, 1)};
        vecs[9]  = '{32'h008000EF, mk(1, 0, 8, 3'd0, 32'h8,        ALU_ADD,   SRC1_PC,  SRC2_IMM, 1, 0, 0, 0, 1, 0)};
        vecs[10] = '{32'hFF812203, mk(4, 2, 24, 3'd2, 32'hFFFFFFF8, ALU_ADD,  SRC1_RS1, SRC2_IMM, 1, 1, 0, 0, 0, 0)};
        vecs[11] = '{32'h0051A623, mk(12, 3, 5, 3'd2, 32'hC,       ALU_ADD,   SRC1_RS1, SRC2_IMM, 0, 0, 1, 0, 0, 0)};
        vecs[12] = '{32'h00001397, mk(7, 0, 0, 3'd1, 32'h1000,     ALU_ADD,   SRC1_PC,  SRC2_IMM, 1, 0, 0, 0, 0, 0)};
        vecs[13] = '{32'h003120B3, mk(1, 2, 3, 3'd2, 32'h3,        ALU_LT,    SRC1_RS1, SRC2_RS2, 1, 0, 0, 0, 0, 0)};
        vecs[14] = '{32'h0020D863, mk(16, 1, 2, 3'd5, 32'h10,      ALU_GT,    SRC1_RS1, SRC2_RS2, 0, 0, 0, 1, 0, 0)};
        vecs[15] = '{32'h402091B3, mk(3, 1, 2, 3'd1, 32'h402,      ALU_SLL,   SRC1_RS1, SRC2_RS2, 0, 0, 0, 0, 0, 1)};
        vecs[16] = '{32'h000110E7, mk(1, 2, 0, 3'd1, 32'h0,        ALU_ADD,   SRC1_RS1, SRC2_IMM, 0, 0, 0, 0, 0, 1)};
        vecs[17] = '{32'h20335293, mk(5, 6, 3, 3'd5, 32'h3,        ALU_SRL,   SRC1_RS1, SRC2_IMM, 0, 0, 0, 0, 0, 1)};
        vecs[18] = '{32'h0020A063, mk(0, 1, 2, 3'd2, 32'h0,        ALU_ADD,   SRC1_RS1, SRC2_RS2, 0, 0, 0, 0, 0, 1)};
        vecs[19] = '{32'hC0000093, mk(1, 0, 0, 3'd0, 32'hFFFFFC00, ALU_ADD,   SRC1_RS1, SRC2_IMM, 1, 0, 0, 0, 0, 0)};

        // Reset state.
        rst = 1'b1;
        idle(1'b1);
        repeat (2) @(negedge clk);
        checkSignal("reset_out_valid", {31'b0, out_valid}, 32'd0);
        checkSignal("reset_in_ready", {31'b0, in_ready}, 32'd1);
        checkSignal("reset_out_pc", out_pc, 32'd0);
        checkSignal("reset_out_imm", out_imm, 32'd0);
        checkSignal("reset_alu_op", {28'b0, out_alu_op}, {28'b0, ALU_ADD});
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back streaming with no backpressure.
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(4 * i), vecs[i].exp, 1'b1, 1'b0);
            stepCycle();
            checkSignal("stream_out_valid", {31'b0, out_valid}, 32'd1);
            checkSignal("stream_in_ready", {31'b0, in_ready}, 32'd1);
        end
        drain("stream");

        // Backpressure: LUI held, ADDI parked in the skid, third input refused.
        applyStimulus(1'b1, vecs[4].instr, 32'h2000, vecs[4].exp, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, vecs[5].instr, 32'h2004, vecs[5].exp, 1'b0, 1'b0);
        stepCycle();
        checkSignal("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
        checkSignal("bp_out_valid", {31'b0, out_valid}, 32'd1);
        applyStimulus(1'b1, vecs[0].instr, 32'h2008, vecs[0].exp, 1'b0, 1'b0);
        stepCycle();
        checkSignal("bp_hold_imm", out_imm, 32'h12345000);
        checkSignal("bp_hold_alu_op", {28'b0, out_alu_op}, {28'b0, ALU_BPS2});
        checkSignal("bp_hold_pc", out_pc, 32'h2000);
        checkSignal("bp_in_ready_still_low", {31'b0, in_ready}, 32'd0);
        idle(1'b1);
        stepCycle();
        checkSignal("bp_skid_to_out_valid", {31'b0, out_valid}, 32'd1);
        checkSignal("bp_skid_to_out_pc", out_pc, 32'h2004);
        checkSignal("bp_in_ready_back", {31'b0, in_ready}, 32'd1);
        drain("bp");

        // Flush with the skid full and a new instruction offered.
        applyStimulus(1'b1, vecs[4].instr, 32'h3000, vecs[4].exp, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, vecs[5].instr, 32'h3004, vecs[5].exp, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, vecs[9].instr, 32'h3008, vecs[9].exp, 1'b0, 1'b1);
        stepCycle();
        checkSignal("flush_full_out_valid", {31'b0, out_valid}, 32'd0);
        checkSignal("flush_full_in_ready", {31'b0, in_ready}, 32'd1);
        drain("flush_full");

        // Flush while an input is accepted in the same cycle: it is discarded.
        applyStimulus(1'b1, vecs[4].instr, 32'h3100, vecs[4].exp, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, vecs[5].instr, 32'h3104, vecs[5].exp, 1'b1, 1'b1);
        stepCycle();
        checkSignal("flush_accept_out_valid", {31'b0, out_valid}, 32'd0);
        checkSignal("flush_accept_in_ready", {31'b0, in_ready}, 32'd1);
        drain("flush_accept");

        // Asynchronous reset in the middle of a stall.
        applyStimulus(1'b1, vecs[4].instr, 32'h4000, vecs[4].exp, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, vecs[5].instr, 32'h4004, vecs[5].exp, 1'b0, 1'b0);
        stepCycle();
        rst = 1'b1;
        #1;
        checkSignal("midreset_out_valid", {31'b0, out_valid}, 32'd0);
        checkSignal("midreset_in_ready", {31'b0, in_ready}, 32'd1);
        checkSignal("midreset_out_imm", out_imm, 32'd0);
        exp_q.delete();
        idle(1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, vecs[0].instr, 32'h5000, vecs[0].exp, 1'b1, 1'b0);
        stepCycle();
        drain("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
